// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period of PWM_IN in CLK
// cycles, flags short, long and missing pulses, and reports a lock status.
module servo_pwm_decoder #(
  parameter int CNT_W      = 32,
  parameter int MIN_WIDTH  = 50000,
  parameter int MAX_WIDTH  = 250000,
  parameter int TIMEOUT    = 2500000,
  parameter int LOCK_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             width_valid,
  output logic             period_valid,
  output logic             err_short,
  output logic             err_long,
  output logic             err_timeout,
  output logic             locked
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_COUNT);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DEAD
  } state_t;

  // Counters stick at all-ones so an endless pulse still reads as too long.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic [LOCK_W-1:0] lock_inc(input logic [LOCK_W-1:0] v);
    return (v >= LOCK_MAX) ? LOCK_MAX : v + LOCK_ONE;
  endfunction

  logic             sync1_q, sync2_q;
  logic             pwm_s_q, pwm_d_q;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             width_valid_q, width_valid_d;
  logic             period_valid_q, period_valid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             err_timeout_q, err_timeout_d;

  logic rise, fall, pipe_full, quiet_expired;

  // Stage: synchronizer and edge-detect pipeline
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= PWM_IN;
      sync2_q <= sync1_q;
      pwm_s_q <= sync2_q;
      pwm_d_q <= pwm_s_q;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end
  end

  assign rise          = pwm_s_q & ~pwm_d_q;
  assign fall          = ~pwm_s_q & pwm_d_q;
  assign pipe_full     = (fill_q == 2'd3);
  assign quiet_expired = (quiet_cnt_q >= TIMEOUT_C);

  // Stage: measurement FSM, next state and registered outputs
  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    hi_cnt_d       = sat_inc(hi_cnt_q);
    per_cnt_d      = sat_inc(per_cnt_q);
    quiet_cnt_d    = sat_inc(quiet_cnt_q);
    lock_cnt_d     = lock_cnt_q;
    locked_d       = locked_q;
    pulse_width_d  = pulse_width_q;
    period_d       = period_q;
    width_valid_d  = 1'b0;
    period_valid_d = 1'b0;
    err_short_d    = 1'b0;
    err_long_d     = 1'b0;
    err_timeout_d  = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // Only trust a rise once the line has been seen low after reset.
        if (armed_q && rise) begin
          state_d     = ST_HIGH;
          hi_cnt_d    = ONE;
          per_cnt_d   = ONE;
          quiet_cnt_d = ONE;
        end else begin
          armed_d = armed_q | (pipe_full & ~pwm_s_q);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d     = ST_LOW;
          quiet_cnt_d = ONE;
          if (hi_cnt_q < MIN_C) begin
            err_short_d = 1'b1;
            lock_cnt_d  = '0;
            locked_d    = 1'b0;
          end else if (hi_cnt_q > MAX_C) begin
            err_long_d = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end else begin
            pulse_width_d = hi_cnt_q;
            width_valid_d = 1'b1;
            lock_cnt_d    = lock_inc(lock_cnt_q);
            locked_d      = (lock_inc(lock_cnt_q) == LOCK_MAX);
          end
        end else if (quiet_expired) begin
          state_d       = ST_DEAD;
          err_timeout_d = 1'b1;
          lock_cnt_d    = '0;
          locked_d      = 1'b0;
        end
      end

      ST_LOW: begin
        if (rise) begin
          period_d       = per_cnt_q;
          period_valid_d = 1'b1;
          state_d        = ST_HIGH;
          hi_cnt_d       = ONE;
          per_cnt_d      = ONE;
          quiet_cnt_d    = ONE;
        end else if (quiet_expired) begin
          state_d       = ST_DEAD;
          err_timeout_d = 1'b1;
          lock_cnt_d    = '0;
          locked_d      = 1'b0;
        end
      end

      ST_DEAD: begin
        // No valid previous rise exists, so this rise starts a fresh period.
        if (rise) begin
          err_timeout_d = 1'b0;
          state_d       = ST_HIGH;
          hi_cnt_d      = ONE;
          per_cnt_d     = ONE;
          quiet_cnt_d   = ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      armed_q        <= 1'b0;
      hi_cnt_q       <= '0;
      per_cnt_q      <= '0;
      quiet_cnt_q    <= '0;
      lock_cnt_q     <= '0;
      locked_q       <= 1'b0;
      pulse_width_q  <= '0;
      period_q       <= '0;
      width_valid_q  <= 1'b0;
      period_valid_q <= 1'b0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      hi_cnt_q       <= hi_cnt_d;
      per_cnt_q      <= per_cnt_d;
      quiet_cnt_q    <= quiet_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      locked_q       <= locked_d;
      pulse_width_q  <= pulse_width_d;
      period_q       <= period_d;
      width_valid_q  <= width_valid_d;
      period_valid_q <= period_valid_d;
      err_short_q    <= err_short_d;
      err_long_q     <= err_long_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign pulse_width  = pulse_width_q;
  assign period       = period_q;
  assign width_valid  = width_valid_q;
  assign period_valid = period_valid_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign err_timeout  = err_timeout_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with small width/timeout limits.
module tb_servo_pwm_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PWM_IN = 1'b0;
  logic [31:0] pulse_width;
  logic [31:0] period;
  logic        width_valid;
  logic        period_valid;
  logic        err_short;
  logic        err_long;
  logic        err_timeout;
  logic        locked;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int wv_n = 0, pv_n = 0, es_n = 0, el_n = 0, ov_n = 0;
  int wv0, pv0, es0, el0;

  servo_pwm_decoder #(
    .CNT_W(32), .MIN_WIDTH(5), .MAX_WIDTH(25), .TIMEOUT(250), .LOCK_COUNT(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PWM_IN(PWM_IN),
    .pulse_width(pulse_width),
    .period(period),
    .width_valid(width_valid),
    .period_valid(period_valid),
    .err_short(err_short),
    .err_long(err_long),
    .err_timeout(err_timeout),
    .locked(locked)
  );

  always #5 CLK = ~CLK;

  // Strobe tally sampled on the falling edge, away from output updates.
  always @(negedge CLK) begin
    if (width_valid)  wv_n++;
    if (period_valid) pv_n++;
    if (err_short)    es_n++;
    if (err_long)     el_n++;
    if ((32'(width_valid) + 32'(err_short) + 32'(err_long)) > 1) ov_n++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int hi, input int per);
    PWM_IN = 1'b1;
    ticks(hi);
    PWM_IN = 1'b0;
    ticks(per - hi);
  endtask

  task automatic snap();
    wv0 = wv_n; pv0 = pv_n; es0 = es_n; el0 = el_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pw"}, pulse_width, 32'd0);
    chk({tag, "_per"}, period, 32'd0);
    chk({tag, "_strobes"}, {28'd0, width_valid, period_valid, err_short, err_long}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, "_lock"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    ticks(3);
    chk_all_zero("reset");
    RST = 1'b0;
    ticks(5);

    // 1: four 15/100 pulses, lock on the third accepted width
    snap();
    pulse(15, 100);
    pulse(15, 100);
    PWM_IN = 1'b1;
    ticks(15);
    PWM_IN = 1'b0;
    ticks(3);
    chk("t1_wv_before", {31'd0, width_valid}, 32'd0);
    chk("t1_lock_before", {31'd0, locked}, 32'd0);
    tick();
    chk("t1_wv_at_fall3", {31'd0, width_valid}, 32'd1);
    chk("t1_lock_at_fall3", {31'd0, locked}, 32'd1);
    chk("t1_pw", pulse_width, 32'd15);
    tick();
    chk("t1_wv_one_cycle", {31'd0, width_valid}, 32'd0);
    ticks(80);
    pulse(15, 100);
    chk("t1_wv_count", 32'(wv_n - wv0), 32'd4);
    chk("t1_pv_count", 32'(pv_n - pv0), 32'd3);
    chk("t1_period", period, 32'd100);
    chk("t1_locked", {31'd0, locked}, 32'd1);

    // 2: short pulse while locked, then relock after three good pulses
    snap();
    PWM_IN = 1'b1;
    ticks(3);
    PWM_IN = 1'b0;
    ticks(3);
    chk("t2_es_before", {31'd0, err_short}, 32'd0);
    chk("t2_lock_before", {31'd0, locked}, 32'd1);
    tick();
    chk("t2_es_at_fall3", {31'd0, err_short}, 32'd1);
    chk("t2_lock_cleared", {31'd0, locked}, 32'd0);
    chk("t2_pw_kept", pulse_width, 32'd15);
    tick();
    chk("t2_es_one_cycle", {31'd0, err_short}, 32'd0);
    ticks(92);
    chk("t2_es_count", 32'(es_n - es0), 32'd1);
    chk("t2_wv_count", 32'(wv_n - wv0), 32'd0);
    pulse(15, 100);
    pulse(15, 100);
    chk("t2_lock_after2", {31'd0, locked}, 32'd0);
    pulse(15, 100);
    chk("t2_relock_after3", {31'd0, locked}, 32'd1);

    // 3: 40-cycle pulse is too long
    snap();
    pulse(40, 100);
    chk("t3_el_count", 32'(el_n - el0), 32'd1);
    chk("t3_wv_count", 32'(wv_n - wv0), 32'd0);
    chk("t3_locked", {31'd0, locked}, 32'd0);
    chk("t3_pw_kept", pulse_width, 32'd15);

    // 4: relock, then hold the line low until it is declared dead
    pulse(15, 100);
    pulse(15, 100);
    PWM_IN = 1'b1;
    ticks(15);
    PWM_IN = 1'b0;
    ticks(4);
    chk("t4_locked_pre", {31'd0, locked}, 32'd1);
    ticks(249);
    chk("t4_tmo_not_yet", {31'd0, err_timeout}, 32'd0);
    chk("t4_lock_not_yet", {31'd0, locked}, 32'd1);
    tick();
    chk("t4_tmo_set", {31'd0, err_timeout}, 32'd1);
    chk("t4_lock_dropped", {31'd0, locked}, 32'd0);
    ticks(46);
    chk("t4_tmo_held", {31'd0, err_timeout}, 32'd1);
    snap();
    PWM_IN = 1'b1;
    ticks(3);
    chk("t4_tmo_until_rise", {31'd0, err_timeout}, 32'd1);
    tick();
    chk("t4_tmo_cleared", {31'd0, err_timeout}, 32'd0);
    ticks(11);
    PWM_IN = 1'b0;
    ticks(85);
    chk("t4_no_period_after_dead", 32'(pv_n - pv0), 32'd0);
    pulse(15, 100);
    chk("t4_period_resumes", 32'(pv_n - pv0), 32'd1);
    chk("t4_period_val", period, 32'd100);

    // 5: line already high when reset is released
    RST = 1'b1;
    PWM_IN = 1'b1;
    ticks(3);
    RST = 1'b0;
    snap();
    ticks(10);
    PWM_IN = 1'b0;
    ticks(20);
    chk("t5_no_strobe", 32'((wv_n - wv0) + (es_n - es0) + (el_n - el0)), 32'd0);
    chk("t5_pw_reset", pulse_width, 32'd0);
    pulse(15, 100);
    chk("t5_wv_count", 32'(wv_n - wv0), 32'd1);
    chk("t5_pw", pulse_width, 32'd15);
    chk("t5_no_period", 32'(pv_n - pv0), 32'd0);

    // 6: reset in the middle of a high phase of a locked stream
    pulse(15, 100);
    pulse(15, 100);
    chk("t6_locked_pre", {31'd0, locked}, 32'd1);
    PWM_IN = 1'b1;
    ticks(7);
    RST = 1'b1;
    #1;
    chk_all_zero("t6_async");
    ticks(2);
    RST = 1'b0;
    snap();
    ticks(6);
    PWM_IN = 1'b0;
    ticks(85);
    chk("t6_partial_discarded", 32'((wv_n - wv0) + (es_n - es0) + (el_n - el0) + (pv_n - pv0)), 32'd0);
    pulse(15, 100);
    pulse(15, 100);
    chk("t6_wv_count", 32'(wv_n - wv0), 32'd2);
    chk("t6_pv_count", 32'(pv_n - pv0), 32'd1);
    chk("t6_period", period, 32'd100);
    chk("t6_pw", pulse_width, 32'd15);

    chk("no_overlapping_strobes", 32'(ov_n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generators in sp_optimizer.
- Samples a servo PWM line (SERVO_H or SERVO_V) and measures high time and period in CLK cycles.
- Flags malformed or missing pulses and reports a lock status.
- Used in TEST_MODE benches and as an on-FPGA loopback monitor, so servo_position_H/V can be checked against the pulse actually driven.

Parameters:
- CNT_W, 32, width of all counters and measurement outputs.
- MIN_WIDTH, 50000, minimum legal high time in cycles (0.5 ms at 100 MHz).
- MAX_WIDTH, 250000, maximum legal high time in cycles (2.5 ms).
- TIMEOUT, 2500000, cycles with no edge before the line is declared dead (25 ms).
- LOCK_COUNT, 3, consecutive accepted pulses required to assert locked.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- PWM_IN  in  1  asynchronous PWM line under measurement.
- pulse_width  out  CNT_W  last accepted high time, in cycles.
- period  out  CNT_W  last measured rising-to-rising period, in cycles.
- width_valid  out  1  one-cycle strobe: pulse_width updated.
- period_valid  out  1  one-cycle strobe: period updated.
- err_short  out  1  one-cycle strobe: high time < MIN_WIDTH.
- err_long  out  1  one-cycle strobe: high time > MAX_WIDTH.
- err_timeout  out  1  level: line dead; clears on the next rising edge.
- locked  out  1  level: LOCK_COUNT consecutive accepted pulses, no error since.

Behaviour:
- Reset (asynchronous, RST=1): every output is 0. Counters, lock counter and synchronizer are cleared. FSM goes to IDLE.
- Synchronization: PWM_IN passes through a 2-FF synchronizer, then an edge-detect register giving pwm_s and pwm_d. Rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
- FSM states: IDLE, HIGH, LOW, DEAD.
- IDLE: wait for rise; a line already high at reset release is ignored until it goes low and rises again. On rise: go to HIGH, hi_cnt=1, per_cnt=1.
- HIGH: hi_cnt and per_cnt increment each cycle, saturating at all-ones. On fall, judge the width w=hi_cnt:
  - w < MIN_WIDTH: err_short pulses; pulse_width unchanged.
  - w > MAX_WIDTH: err_long pulses; pulse_width unchanged.
  - Otherwise: pulse_width<=w and width_valid pulses.
  - In every case go to LOW; per_cnt keeps counting.
- LOW: per_cnt increments. On rise: period<=per_cnt and period_valid pulses, except on the first rise after IDLE/DEAD (no prior rise, so no period is reported). Then go to HIGH with hi_cnt=1, per_cnt=1.
- Timeout: in HIGH or LOW, if no edge occurs for TIMEOUT consecutive cycles, go to DEAD, set err_timeout=1 and locked=0.
- DEAD: on rise, clear err_timeout and enter HIGH as from IDLE (period not reported).
- Latency: width_valid/err_* assert exactly 3 CLK cycles after the first posedge sampling PWM_IN low; period_valid likewise after the rising sample. Measured values equal the number of posedges at which PWM_IN was sampled high (width) or rise-to-rise (period), exactly, for a clean input.
- Lock: an accepted pulse increments lock_cnt (saturating at LOCK_COUNT); locked=1 once lock_cnt==LOCK_COUNT. err_short, err_long or timeout clear lock_cnt and locked in the same cycle as the error strobe.
- Simultaneous events: a rise on the same cycle the timeout count would expire takes priority, so no timeout. Strobes never overlap: at most one of width_valid/err_short/err_long per fall.
- Widths: comparisons are unsigned on CNT_W bits; saturated counters always classify as err_long or timeout.
- Reset mid-pulse: outputs clear immediately. After release, the partial pulse is discarded (IDLE waits for a fresh rise).

Test Plan:
Bench overrides MIN_WIDTH=5, MAX_WIDTH=25, TIMEOUT=250, LOCK_COUNT=3; CLK 10 ns.
1. Reset, then 4 pulses of 15 cycles high, 100-cycle period -> width_valid x4 with pulse_width=15; period_valid x3 with period=100; locked=1 at the 3rd width_valid, 3 cycles after its fall.
2. While locked, one 3-cycle pulse -> err_short one cycle, pulse_width stays 15, locked=0; needs 3 further good pulses to relock.
3. One 40-cycle pulse -> err_long one cycle, no width_valid, locked=0.
4. Hold PWM_IN low 300 cycles after a pulse -> err_timeout=1 at 250 cycles after the last edge (+3 sync), locked=0; next rise clears it; the first following period is not reported.
5. PWM_IN high before RST falls, fall after 10 cycles -> no strobe; the next full 15-cycle pulse gives width_valid with 15.
6. Assert RST for 2 cycles mid-high of a locked stream -> all outputs 0 within the reset cycle; the partial pulse is discarded; normal measurement resumes on the next rise.
